// File: rtl/if_pc_redirect_pkg.sv
// Shared encodings for the IF-stage PC sequencer.
// Early-jump codes from ID and fetch FSM states.
package if_pc_redirect_pkg;

  localparam logic [1:0] EJ_JAL  = 2'b01;
  localparam logic [1:0] EJ_JALR = 2'b10;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    SRC_SEQ = 2'b00,
    SRC_ID  = 2'b01,
    SRC_EX  = 2'b10
  } redir_src_e;

endpackage

// File: rtl/if_redirect_arb.sv
// Redirect priority select: EX branch over ID early jump.
// Produces target, flush strobes and misalignment flag.
module if_redirect_arb
  import if_pc_redirect_pkg::*;
#(
  parameter int IAW = 32
) (
  input  logic           i_en,
  input  logic [1:0]     i_early_jump,
  input  logic [IAW-1:0] i_jal_res,
  input  logic [IAW-1:0] i_jalr_res,
  input  logic           i_br_taken,
  input  logic [IAW-1:0] i_br_target,
  output logic           o_redirect,
  output logic [IAW-1:0] o_target,
  output logic           o_flush_id,
  output logic           o_flush_ex,
  output logic           o_misalign
);

  redir_src_e     w_src;
  logic [IAW-1:0] w_tgt;

  always_comb begin
    w_src = SRC_SEQ;
    w_tgt = '0;
    priority case (1'b1)
      i_br_taken: begin
        w_src = SRC_EX;
        w_tgt = i_br_target;
      end
      (i_early_jump == EJ_JAL): begin
        w_src = SRC_ID;
        w_tgt = i_jal_res;
      end
      (i_early_jump == EJ_JALR): begin
        w_src = SRC_ID;
        w_tgt = {i_jalr_res[IAW-1:1], 1'b0};
      end
      default: begin
        w_src = SRC_SEQ;
        w_tgt = '0;
      end
    endcase
  end

  // the ID instruction is itself wrong-path when EX redirects
  assign o_redirect = i_en & (w_src != SRC_SEQ);
  assign o_target   = w_tgt;
  assign o_flush_id = o_redirect;
  assign o_flush_ex = i_en & (w_src == SRC_EX);
  assign o_misalign = o_redirect & w_tgt[1];

endmodule

// File: rtl/if_pc_redirect.sv
// IF-stage PC sequencer: fetch PC, imem handshake,
// pending redirect while imem is busy.
module if_pc_redirect
  import if_pc_redirect_pkg::*;
#(
  parameter int INST_ADDR_WIDTH = 32,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall_IF,
  input  logic [1:0]                 early_jump,
  input  logic [INST_ADDR_WIDTH-1:0] early_jump_jal_res,
  input  logic [INST_ADDR_WIDTH-1:0] early_jump_jalr_res,
  input  logic                       branch_taken_EX,
  input  logic [INST_ADDR_WIDTH-1:0] branch_target_EX,
  input  logic                       imem_ready,
  output logic                       imem_req,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  output logic [INST_ADDR_WIDTH-1:0] PC_IF,
  output logic                       inst_valid_IF,
  output logic                       flush_ID,
  output logic                       flush_EX,
  output logic                       misalign_err
);

  localparam int IAW = INST_ADDR_WIDTH;
  localparam logic [IAW-1:0] PC_STEP = IAW'(4);

  fetch_state_e   r_state;
  logic           r_req;
  logic [IAW-1:0] r_pc;
  logic [IAW-1:0] r_tgt;

  logic           w_redirect;
  logic [IAW-1:0] w_target;

  if_redirect_arb #(
    .IAW(IAW)
  ) u_arb (
    .i_en        (rst_n),
    .i_early_jump(early_jump),
    .i_jal_res   (early_jump_jal_res),
    .i_jalr_res  (early_jump_jalr_res),
    .i_br_taken  (branch_taken_EX),
    .i_br_target (branch_target_EX),
    .o_redirect  (w_redirect),
    .o_target    (w_target),
    .o_flush_id  (flush_ID),
    .o_flush_ex  (flush_EX),
    .o_misalign  (misalign_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_req   <= 1'b0;
      r_pc    <= RESET_PC;
      r_tgt   <= '0;
    end else begin
      r_req <= 1'b1;
      // no request outstanding yet, so the address may move freely
      if (!r_req) begin
        if (w_redirect) r_pc <= w_target;
      end else begin
        unique case (r_state)
          RUN: begin
            if (imem_ready) begin
              if (w_redirect) r_pc <= w_target;
              else if (!stall_IF) r_pc <= r_pc + PC_STEP;
            end else if (w_redirect) begin
              r_tgt   <= w_target;
              r_state <= PEND;
            end
          end
          PEND: begin
            if (imem_ready) begin
              r_pc    <= w_redirect ? w_target : r_tgt;
              r_state <= RUN;
            end else if (w_redirect) begin
              r_tgt <= w_target;
            end
          end
          default: r_state <= RUN;
        endcase
      end
    end
  end

  assign imem_req      = r_req;
  assign imem_addr     = r_pc;
  assign PC_IF         = r_pc;
  assign inst_valid_IF = rst_n & r_req & (r_state == RUN) & imem_ready
                       & ~w_redirect & ~stall_IF;

endmodule

// File: tb/tb_if_pc_redirect.sv
// Bench for if_pc_redirect: directed scenarios plus
// randomized traffic against a behavioural fetch model.
module tb_if_pc_redirect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_IF;
  logic [1:0]  early_jump;
  logic [31:0] jal_res, jalr_res, br_tgt;
  logic        br_taken, imem_ready;
  logic        imem_req, inst_valid_IF, flush_ID, flush_EX, misalign_err;
  logic [31:0] imem_addr, PC_IF;

  int n_vec = 0;
  int n_err = 0;

  bit          m_req, m_pend;
  logic [31:0] m_pc, m_tgt;
  bit          e_red, e_fid, e_fex, e_mis, e_val;
  logic [31:0] e_t;

  always #5 clk = ~clk;

  if_pc_redirect #(.INST_ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall_IF(stall_IF),
    .early_jump(early_jump), .early_jump_jal_res(jal_res),
    .early_jump_jalr_res(jalr_res), .branch_taken_EX(br_taken),
    .branch_target_EX(br_tgt), .imem_ready(imem_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .PC_IF(PC_IF),
    .inst_valid_IF(inst_valid_IF), .flush_ID(flush_ID),
    .flush_EX(flush_EX), .misalign_err(misalign_err)
  );

  task automatic set_in(input bit st, input bit [1:0] ej,
                        input logic [31:0] jl, input logic [31:0] jr,
                        input bit bt, input logic [31:0] btv,
                        input bit rdy);
    stall_IF = st; early_jump = ej; jal_res = jl; jalr_res = jr;
    br_taken = bt; br_tgt = btv; imem_ready = rdy;
  endtask

  task automatic idle_in();
    set_in(0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 1);
  endtask

  // expected combinational outputs from the priority rules
  task automatic eval();
    e_red = 0; e_fid = 0; e_fex = 0; e_t = 32'h0;
    if (br_taken) begin
      e_red = 1; e_fid = 1; e_fex = 1; e_t = br_tgt;
    end else if (early_jump == 2'b01) begin
      e_red = 1; e_fid = 1; e_t = jal_res;
    end else if (early_jump == 2'b10) begin
      e_red = 1; e_fid = 1; e_t = jalr_res & ~32'd1;
    end
    if (!rst_n) begin e_red = 0; e_fid = 0; e_fex = 0; end
    e_mis = e_red && e_t[1];
    e_val = rst_n && m_req && !m_pend && imem_ready && !e_red && !stall_IF;
  endtask

  task automatic tick();
    eval();
    @(posedge clk);
    if (!rst_n) begin
      m_req = 0; m_pend = 0; m_pc = 32'h0; m_tgt = 32'h0;
    end else if (!m_req) begin
      if (e_red) m_pc = e_t;
      m_req = 1;
    end else if (m_pend) begin
      if (imem_ready) begin
        m_pc = e_red ? e_t : m_tgt;
        m_pend = 0;
      end else if (e_red) m_tgt = e_t;
    end else if (imem_ready) begin
      if (e_red) m_pc = e_t;
      else if (!stall_IF) m_pc = m_pc + 32'd4;
    end else if (e_red) begin
      m_pend = 1; m_tgt = e_t;
    end
    @(negedge clk);
  endtask

  task automatic go(input logic [31:0] pc);
    set_in(0, 2'b01, pc, 32'h0, 0, 32'h0, 1);
    tick();
    idle_in();
  endtask

  task automatic test_reset();
    logic [31:0] exp_a;
    rst_n = 0;
    set_in(0, 2'b01, 32'h44, 32'h0, 1, 32'h88, 1);
    @(negedge clk);
    tick();
    #1;
    n_vec++;
    if ({imem_req, inst_valid_IF, flush_ID, flush_EX, misalign_err} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outs: got %b exp 00000",
        {imem_req, inst_valid_IF, flush_ID, flush_EX, misalign_err});
    end
    tick();
    rst_n = 1;
    idle_in();
    #1;
    n_vec++;
    if ({imem_req, imem_addr} !== {1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_release: req=%b addr=%h exp 0 0", imem_req, imem_addr);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_a = 32'(i * 4);
      n_vec++;
      if ({imem_req, imem_addr, inst_valid_IF} !== {1'b1, exp_a, 1'b1}) begin
        n_err++;
        $display("FAIL reset_seq%0d: req=%b addr=%h v=%b exp 1 %h 1",
          i, imem_req, imem_addr, inst_valid_IF, exp_a);
      end
      tick();
    end
  endtask

  task automatic test_jal();
    go(32'h10);
    set_in(0, 2'b01, 32'h80, 32'h0, 0, 32'h0, 1);
    #1;
    n_vec++;
    if ({imem_addr, flush_ID, flush_EX, inst_valid_IF} !== {32'h10, 3'b100}) begin
      n_err++;
      $display("FAIL jal_flush: addr=%h fid=%b fex=%b v=%b exp 10 1 0 0",
        imem_addr, flush_ID, flush_EX, inst_valid_IF);
    end
    tick();
    idle_in();
    #1;
    n_vec++;
    if (imem_addr !== 32'h80) begin
      n_err++;
      $display("FAIL jal_addr: got %h exp 00000080", imem_addr);
    end
  endtask

  task automatic test_conflict();
    set_in(0, 2'b10, 32'h0, 32'h41, 1, 32'h200, 1);
    #1;
    n_vec++;
    if ({flush_ID, flush_EX} !== 2'b11) begin
      n_err++;
      $display("FAIL conflict_flush: fid=%b fex=%b exp 1 1", flush_ID, flush_EX);
    end
    tick();
    set_in(0, 2'b10, 32'h0, 32'h41, 0, 32'h0, 1);
    #1;
    n_vec++;
    if ({imem_addr, flush_EX, misalign_err} !== {32'h200, 2'b00}) begin
      n_err++;
      $display("FAIL conflict_addr: addr=%h fex=%b mis=%b exp 200 0 0",
        imem_addr, flush_EX, misalign_err);
    end
    tick();
    idle_in();
    #1;
    n_vec++;
    if (imem_addr !== 32'h40) begin
      n_err++;
      $display("FAIL jalr_align: got %h exp 00000040", imem_addr);
    end
  endtask

  task automatic test_stall();
    go(32'h20);
    for (int i = 0; i < 3; i++) begin
      set_in(1, 2'b00, 32'h0, 32'h0, 0, 32'h0, 1);
      tick();
      #1;
      n_vec++;
      if ({imem_addr, inst_valid_IF} !== {32'h20, 1'b0}) begin
        n_err++;
        $display("FAIL stall_hold%0d: addr=%h v=%b exp 20 0", i, imem_addr, inst_valid_IF);
      end
    end
    set_in(1, 2'b01, 32'h100, 32'h0, 0, 32'h0, 1);
    tick();
    idle_in();
    #1;
    n_vec++;
    if (imem_addr !== 32'h100) begin
      n_err++;
      $display("FAIL stall_redirect: got %h exp 00000100", imem_addr);
    end
  endtask

  task automatic test_busy();
    go(32'h30);
    set_in(0, 2'b01, 32'h90, 32'h0, 0, 32'h0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0);
      #1;
      n_vec++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h30}) begin
        n_err++;
        $display("FAIL busy_hold%0d: req=%b addr=%h exp 1 30", i, imem_req, imem_addr);
      end
      tick();
    end
    idle_in();
    #1;
    n_vec++;
    if (inst_valid_IF !== 1'b0) begin
      n_err++;
      $display("FAIL busy_discard: v=%b exp 0", inst_valid_IF);
    end
    tick();
    #1;
    n_vec++;
    if (imem_addr !== 32'h90) begin
      n_err++;
      $display("FAIL busy_addr: got %h exp 00000090", imem_addr);
    end
  endtask

  task automatic test_edge();
    go(32'hFFFF_FFFC);
    tick();
    #1;
    n_vec++;
    if (imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL wrap: got %h exp 00000000", imem_addr);
    end
    set_in(0, 2'b01, 32'h102, 32'h0, 0, 32'h0, 1);
    #1;
    n_vec++;
    if (misalign_err !== 1'b1) begin
      n_err++;
      $display("FAIL misalign_pulse: got %b exp 1", misalign_err);
    end
    tick();
    idle_in();
    #1;
    n_vec++;
    if ({imem_addr, misalign_err} !== {32'h102, 1'b0}) begin
      n_err++;
      $display("FAIL misalign_addr: addr=%h mis=%b exp 102 0", imem_addr, misalign_err);
    end
    set_in(0, 2'b01, 32'h700, 32'h0, 0, 32'h0, 0);
    tick();
    rst_n = 0;
    set_in(0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0);
    tick();
    rst_n = 1;
    idle_in();
    tick();
    tick();
    #1;
    n_vec++;
    if ({imem_addr, inst_valid_IF} !== {32'h4, 1'b1}) begin
      n_err++;
      $display("FAIL pend_reset: addr=%h v=%b exp 4 1", imem_addr, inst_valid_IF);
    end
  endtask

  task automatic test_random();
    bit [1:0]    ej;
    logic [31:0] a, b, c;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      a = $urandom & 32'hFFFF_FFFC;
      b = $urandom;
      c = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) a[1] = 1'b1;
      if ($urandom_range(0, 7) == 0) c[1] = 1'b1;
      ej = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      set_in($urandom_range(0, 3) == 0, ej, a, b,
             $urandom_range(0, 7) == 0, c, $urandom_range(0, 2) != 0);
      #1;
      eval();
      n_vec++;
      if ({imem_req, imem_addr, PC_IF, inst_valid_IF, flush_ID, flush_EX, misalign_err}
          !== {m_req, m_pc, m_pc, e_val, e_fid, e_fex, e_mis}) begin
        n_err++;
        $display("FAIL rand%0d: got req=%b addr=%h pc=%h v=%b fid=%b fex=%b mis=%b exp req=%b pc=%h v=%b fid=%b fex=%b mis=%b",
          cyc, imem_req, imem_addr, PC_IF, inst_valid_IF, flush_ID, flush_EX,
          misalign_err, m_req, m_pc, e_val, e_fid, e_fex, e_mis);
      end
      tick();
    end
  endtask

  initial begin
    m_req = 0; m_pend = 0; m_pc = 32'h0; m_tgt = 32'h0;
    test_reset();
    test_jal();
    test_conflict();
    test_stall();
    test_busy();
    test_edge();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
